led_show_arbiter: RTL and testbench

Shares the single 8-bit LED bank between NREQ pattern generators, such as the free-running 7-step pattern engine, all running on the divided slow clock clk1. Generators request the bank with a req/gnt handshake. The arbiter then:
- grants one owner at a time, round-robin, with requester 0 as a high-priority alert source;
- enforces a minimum dwell and a maximum hold per grant;
- inserts one blank (all-off) cycle between owners;
- drives the registered LED output from the owner's pattern.

---
 rtl/led_show_pkg.sv | 14 +
 rtl/led_rr_pick.sv | 40 ++++
 rtl/led_show_arbiter.sv | 101 ++++++++++
 tb/tb_led_show_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/led_show_pkg.sv
// Shared types and constants for the LED bank arbiter.
package led_show_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [7:0] LED_BLANK     = 8'h00;
  localparam int         DEF_DWELL_MIN = 3;
  localparam int         DEF_HOLD_MAX  = 14;

endpackage

// File: rtl/led_rr_pick.sv
// Combinational winner pick: requester 0 always wins, otherwise rotate from last+1.
module led_rr_pick
  import led_show_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic                    any,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic [NREQ-1:0]         onehot
);

  localparam int IW = $clog2(NREQ);

  assign any = |req;

  always_comb begin
    logic             found;
    logic [IW-1:0]    idx;
    winner = '0;
    onehot = '0;
    found  = 1'b0;
    idx    = '0;
    if (req[0]) begin
      found = 1'b1;
    end
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    if (found) begin
      onehot[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/led_show_arbiter.sv
// Round-robin owner of the 8-bit LED bank with dwell/hold limits and a blank gap.
module led_show_arbiter
  import led_show_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DWELL_MIN = DEF_DWELL_MIN,
  parameter int HOLD_MAX  = DEF_HOLD_MAX
) (
  input  logic                    clk1,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         done,
  input  logic [NREQ*8-1:0]       pat_in,
  output logic [NREQ-1:0]         gnt,
  output logic [7:0]              out,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_MAX + 1);

  state_t          state;
  logic [IW-1:0]   last;
  logic [CW-1:0]   hold_cnt;
  logic [7:0]      pats [NREQ];
  logic            pick_any;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_oh;
  logic            rel;

  for (genvar i = 0; i < NREQ; i++) begin : g_pat
    assign pats[i] = pat_in[8*i+7:8*i];
  end

  led_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .last   (last),
    .any    (pick_any),
    .winner (pick_idx),
    .onehot (pick_oh)
  );

  // gnt is the owner's one-hot while holding, so it doubles as the owner mask.
  always_comb begin
    logic own_done;
    logic own_req;
    logic others;
    own_done = |(done & gnt);
    own_req  = |(req & gnt);
    others   = |(req & ~gnt);
    rel = (hold_cnt >= CW'(DWELL_MIN)) &&
          (own_done || !own_req ||
           ((hold_cnt >= CW'(HOLD_MAX)) && others) ||
           ((owner != '0) && req[0]));
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= '0;
      out      <= LED_BLANK;
      busy     <= 1'b0;
      owner    <= '0;
      last     <= IW'(NREQ - 1);
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE, BLANK: begin
          if (pick_any) begin
            owner    <= pick_idx;
            gnt      <= pick_oh;
            out      <= pats[pick_idx];
            hold_cnt <= CW'(1);
            busy     <= 1'b1;
            state    <= HOLD;
          end else if (state == BLANK) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        HOLD: begin
          if (rel) begin
            gnt      <= '0;
            out      <= LED_BLANK;
            last     <= owner;
            hold_cnt <= '0;
            state    <= BLANK;
          end else begin
            out <= pats[owner];
            if (hold_cnt != CW'(HOLD_MAX)) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_show_arbiter.sv
// Directed bench for led_show_arbiter with a per-cycle behavioural model.
module tb_led_show_arbiter;

  localparam int NREQ      = 4;
  localparam int DWELL_MIN = 3;
  localparam int HOLD_MAX  = 14;

  logic              clk1 = 1'b0;
  logic              rst  = 1'b0;
  logic [NREQ-1:0]   req  = '0;
  logic [NREQ-1:0]   done = '0;
  logic [NREQ*8-1:0] pat_in = {8'hF0, 8'h3C, 8'h18, 8'h81};
  logic [NREQ-1:0]   gnt;
  logic [7:0]        out;
  logic              busy;
  logic [1:0]        owner;

  int checks   = 0;
  int failures = 0;

  led_show_arbiter #(.NREQ(NREQ), .DWELL_MIN(DWELL_MIN), .HOLD_MAX(HOLD_MAX)) dut (
    .clk1   (clk1),
    .rst    (rst),
    .req    (req),
    .done   (done),
    .pat_in (pat_in),
    .gnt    (gnt),
    .out    (out),
    .busy   (busy),
    .owner  (owner)
  );

  always #5 clk1 = ~clk1;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] d);
    req  = r;
    done = d;
  endtask

  function automatic bit bit_of(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    return NREQ'(1) << i;
  endfunction

  function automatic logic [7:0] slice_of(input int i);
    logic [NREQ*8-1:0] s;
    s = pat_in >> (8 * i);
    return s[7:0];
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int lst);
    if (r[0]) return 0;
    for (int k = 1; k <= NREQ; k++) begin
      if (bit_of(r, (lst + k) % NREQ)) return (lst + k) % NREQ;
    end
    return -1;
  endfunction

  // Model: m_own is -1 with no owner; m_age counts owned cycles without saturating.
  int         m_own   = -1;
  int         m_age   = 0;
  int         m_last  = NREQ - 1;
  int         m_owner = 0;
  bit         m_blank = 1'b0;
  bit         m_busy  = 1'b0;
  bit         m_other = 1'b0;
  logic [7:0] m_out   = 8'h00;

  always @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      m_own = -1; m_age = 0; m_last = NREQ - 1; m_owner = 0;
      m_blank = 1'b0; m_busy = 1'b0; m_out = 8'h00;
    end else if (m_own >= 0) begin
      m_other = (req & ~onehot(m_own)) != '0;
      if (m_age >= DWELL_MIN &&
          (bit_of(done, m_own) || !bit_of(req, m_own) ||
           (m_age >= HOLD_MAX && m_other) || (m_own != 0 && req[0]))) begin
        m_last  = m_own;
        m_own   = -1;
        m_blank = 1'b1;
        m_out   = 8'h00;
      end else begin
        m_age++;
        m_out = slice_of(m_own);
      end
    end else if (req != '0) begin
      m_own   = pick(req, m_last);
      m_owner = m_own;
      m_age   = 1;
      m_out   = slice_of(m_own);
      m_busy  = 1'b1;
      m_blank = 1'b0;
    end else begin
      if (m_blank) m_busy = 1'b0;
      m_blank = 1'b0;
    end
  end

  always @(negedge clk1) begin
    checkOutput("cmp_gnt", {4'b0, gnt}, {4'b0, (m_own >= 0) ? onehot(m_own) : 4'b0});
    checkOutput("cmp_out", out, m_out);
    checkOutput("cmp_busy", {7'b0, busy}, {7'b0, m_busy});
    checkOutput("cmp_owner", {6'b0, owner}, 8'(m_owner));
  end

  initial begin
    applyStimulus(4'b0000, 4'b0000);
    repeat (2) @(negedge clk1);
    checkOutput("rst_gnt", {4'b0, gnt}, 8'h00);
    checkOutput("rst_out", out, 8'h00);
    checkOutput("rst_busy", {7'b0, busy}, 8'h00);
    checkOutput("rst_owner", {6'b0, owner}, 8'h00);

    // Single requester 1 gets the bank on the first edge.
    rst = 1'b1;
    applyStimulus(4'b0010, 4'b0000);
    @(negedge clk1);
    checkOutput("t1_gnt", {4'b0, gnt}, 8'h02);
    checkOutput("t1_out", out, 8'h18);
    checkOutput("t1_busy", {7'b0, busy}, 8'h01);
    checkOutput("t1_owner", {6'b0, owner}, 8'h01);

    // Done during dwell is forgotten; the dropped req releases at hold_cnt 3.
    applyStimulus(4'b0010, 4'b0010);
    @(negedge clk1);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("t2_gnt_hc2", {4'b0, gnt}, 8'h02);
    @(negedge clk1);
    checkOutput("t2_gnt_hc3", {4'b0, gnt}, 8'h02);
    @(negedge clk1);
    checkOutput("t2_blank_gnt", {4'b0, gnt}, 8'h00);
    checkOutput("t2_blank_out", out, 8'h00);
    checkOutput("t2_blank_busy", {7'b0, busy}, 8'h01);
    @(negedge clk1);
    checkOutput("t2_idle_busy", {7'b0, busy}, 8'h00);
    checkOutput("t2_idle_owner", {6'b0, owner}, 8'h01);

    // Three contenders rotate 2,3,1 with 14-cycle grants and one blank cycle.
    applyStimulus(4'b1110, 4'b0000);
    for (int n = 0; n < 45; n++) begin
      @(negedge clk1);
      if (n == 0 || n == 13) checkOutput("t3_own2", {4'b0, gnt}, 8'h04);
      if (n == 14 || n == 29 || n == 44) checkOutput("t3_blank", {4'b0, gnt}, 8'h00);
      if (n == 15 || n == 28) checkOutput("t3_own3", {4'b0, gnt}, 8'h08);
      if (n == 30 || n == 43) checkOutput("t3_own1", {4'b0, gnt}, 8'h02);
      if (n == 6) checkOutput("t3_pat_latency", out, 8'h5A);
      if (n == 5) pat_in[23:16] = 8'h5A;
    end

    // Alert source 0 cuts owner 2 short after the dwell.
    applyStimulus(4'b0100, 4'b0000);
    @(negedge clk1);
    checkOutput("t4_own2", {4'b0, gnt}, 8'h04);
    applyStimulus(4'b0101, 4'b0000);
    repeat (2) @(negedge clk1);
    checkOutput("t4_own2_hc3", {4'b0, gnt}, 8'h04);
    @(negedge clk1);
    checkOutput("t4_blank", {4'b0, gnt}, 8'h00);
    @(negedge clk1);
    checkOutput("t4_alert", {4'b0, gnt}, 8'h01);
    checkOutput("t4_alert_owner", {6'b0, owner}, 8'h00);
    applyStimulus(4'b0100, 4'b0000);
    repeat (3) @(negedge clk1);
    checkOutput("t4_blank2", {4'b0, gnt}, 8'h00);
    @(negedge clk1);
    checkOutput("t4_back2", {4'b0, gnt}, 8'h04);

    // A lone requester keeps the bank indefinitely.
    for (int n = 0; n < 40; n++) begin
      @(negedge clk1);
      checkOutput("t5_lone", {4'b0, gnt}, 8'h04);
    end

    // Asynchronous reset mid-hold clears outputs without waiting for an edge.
    #2 rst = 1'b0;
    #1;
    checkOutput("t6_gnt", {4'b0, gnt}, 8'h00);
    checkOutput("t6_out", out, 8'h00);
    checkOutput("t6_busy", {7'b0, busy}, 8'h00);
    applyStimulus(4'b1000, 4'b0000);
    @(negedge clk1);
    rst = 1'b1;
    @(negedge clk1);
    checkOutput("t6_regrant", {4'b0, gnt}, 8'h08);
    checkOutput("t6_out3", out, 8'hF0);
    checkOutput("t6_owner3", {6'b0, owner}, 8'h03);

    @(posedge clk1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
